// File: rtl/moore_seq_pkg.sv
// Shared types and helpers for the moore_seq_det sequence detector.
// Optional match counter is enabled by MOORE_SEQ_CNT_EN.
package moore_seq_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      SCAN  = 2'd2,
      MATCH = 2'd3
   } state_e;

   function automatic int fill_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/moore_seq_det_if.sv
// Serial data, pattern load and status bundle for moore_seq_det.
// match_cnt exists only when MOORE_SEQ_CNT_EN is defined.
interface moore_seq_det_if #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
);
   import moore_seq_pkg::*;

   logic               Din;
   logic               din_valid;
   logic               pat_load;
   logic [PAT_W-1:0]   pat_in;
   logic               Dout;
   logic [STATE_W-1:0] state_o;
`ifdef MOORE_SEQ_CNT_EN
   logic [CNT_W-1:0]   match_cnt;
`endif

   modport master (
      output Din,
      output din_valid,
      output pat_load,
      output pat_in,
`ifdef MOORE_SEQ_CNT_EN
      input  match_cnt,
`endif
      input  Dout,
      input  state_o
   );

   modport slave (
      input  Din,
      input  din_valid,
      input  pat_load,
      input  pat_in,
`ifdef MOORE_SEQ_CNT_EN
      output match_cnt,
`endif
      output Dout,
      output state_o
   );

endinterface

// File: rtl/seq_hist_reg.sv
// History shift register with saturating fill counter.
// Exposes the would-be next values so the FSM can compare ahead.
module seq_hist_reg
   import moore_seq_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int FW    = fill_w(PAT_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic             din_i,
   output logic [PAT_W-1:0] hist_nx_o,
   output logic [FW-1:0]    fill_nx_o
);

   logic [PAT_W-1:0] hist_q, hist_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic             full;

   assign full      = (fill_q == FW'(PAT_W));
   assign hist_nx_o = {hist_q[PAT_W-2:0], din_i};
   assign fill_nx_o = full ? fill_q : fill_q + FW'(1);

   // Clear wins over shift so a non-overlap match can drop its history.
   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      if (clr_i) begin
         hist_d = '0;
         fill_d = '0;
      end else if (en_i) begin
         hist_d = hist_nx_o;
         fill_d = fill_nx_o;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/moore_seq_det.sv
// Parametrised Moore serial pattern detector, runtime-loadable pattern.
// Define MOORE_SEQ_CNT_EN to add the saturating match counter.
module moore_seq_det
   import moore_seq_pkg::*;
#(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
   parameter int               OVERLAP = 1,
   parameter int               CNT_W   = 8
) (
   input logic            clk,
   input logic            rst,
   moore_seq_det_if.slave bus
);

   localparam int FW = fill_w(PAT_W);

   localparam logic [STATE_W-1:0] ST_IDLE  = IDLE;
   localparam logic [STATE_W-1:0] ST_FILL  = FILL;
   localparam logic [STATE_W-1:0] ST_SCAN  = SCAN;
   localparam logic [STATE_W-1:0] ST_MATCH = MATCH;

   logic [STATE_W-1:0] state_q, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d;
   logic               dout_q;
   logic               clr, en, hit, take;
   logic [PAT_W-1:0]   hist_nx;
   logic [FW-1:0]      fill_nx;
   logic               full_nx;

   seq_hist_reg #(
      .PAT_W (PAT_W),
      .FW    (FW)
   ) u_hist (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (clr),
      .en_i      (en),
      .din_i     (bus.Din),
      .hist_nx_o (hist_nx),
      .fill_nx_o (fill_nx)
   );

   assign full_nx = (fill_nx == FW'(PAT_W));
   assign hit     = full_nx && (hist_nx == pat_q);
   assign take    = !bus.pat_load && bus.din_valid && hit;

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      clr     = 1'b0;
      en      = 1'b0;
      if (bus.pat_load) begin
         pat_d   = bus.pat_in;
         clr     = 1'b1;
         state_d = ST_IDLE;
      end else if (bus.din_valid) begin
         en = 1'b1;
         if (hit) begin
            state_d = ST_MATCH;
            clr     = (OVERLAP == 0);
         end else begin
            state_d = full_nx ? ST_SCAN : ST_FILL;
         end
      end else begin
         unique case (1'b1)
            (state_q == ST_MATCH):
               state_d = (OVERLAP != 0) ? ST_SCAN : ST_IDLE;
            default:
               state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pat_q   <= PATTERN;
         dout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         dout_q  <= (state_d == ST_MATCH);
      end
   end

   assign bus.Dout    = dout_q;
   assign bus.state_o = state_q;

`ifdef MOORE_SEQ_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (take && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign bus.match_cnt = cnt_q;
`else
   logic unused_take;
   assign unused_take = take;
`endif

endmodule

// File: doc/moore_seq_det.md
Name: moore_seq_det

Overview:
- Parametrised Moore-type serial sequence detector; next generation of the fixed-pattern single-bit detector FSM.
- Monitors the serial input Din, qualified by din_valid, for a PAT_W-bit pattern. Pattern is runtime-loadable.
- Overlapping or non-overlapping matching is selected by parameter.
- Dout is a registered, state-decoded Moore output. Sits in front of framing/sync logic in serial front-ends.

Parameters:
- PAT_W, 4, pattern length in bits (2..16).
- PATTERN, 4'b1011, pattern loaded at reset; MSB is the first bit received.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history cleared after each match.
- CNT_W, 8, match counter width (optional feature only).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- Din  in  1  serial data bit.
- din_valid  in  1  Din is sampled only when 1.
- pat_load  in  1  load pat_in into the pattern register.
- pat_in  in  PAT_W  new pattern, MSB first.
- Dout  out  1  match flag, high while state == MATCH.
- state_o  out  2  current FSM state, for debug.
- match_cnt  out  CNT_W  saturating match count (MOORE_SEQ_CNT_EN only).

Behaviour:
- Reset: takes priority over all other inputs. Sets
  - state = IDLE, Dout = 0, state_o = 0;
  - history register = 0, fill count = 0;
  - pattern register = PATTERN;
  - match_cnt = 0 (when the counter is compiled in).
- States, encoded in pkg: IDLE (fill = 0), FILL (0 < fill < PAT_W), SCAN (fill = PAT_W, no match), MATCH.
- Accepted bit (din_valid = 1 at the edge):
  - hist <= {hist[PAT_W-2:0], Din};
  - fill increments, saturating at PAT_W.
- Next state after an accepted bit:
  - MATCH if the new fill = PAT_W and the new hist = pattern;
  - otherwise FILL or SCAN according to the new fill.
- Moore output: Dout = (state == MATCH), registered.
  - Rises on the same edge that samples the last pattern bit; visible for exactly one cycle after that edge.
- Leaving MATCH: on the next edge regardless of din_valid.
  - OVERLAP = 1: hist is kept; fill stays PAT_W. A new accepted bit may re-enter MATCH immediately, so back-to-back Dout pulses are legal.
  - OVERLAP = 0: on the edge that enters MATCH, fill is cleared to 0 and hist to 0. The next state is IDLE, or FILL if a bit is accepted on the exit edge (that bit counts as bit 1 of the next search).
- din_valid = 0: hist and fill hold. State holds, except MATCH, which exits as above to SCAN (overlap) or IDLE (non-overlap).
- pat_load = 1 (when rst = 0):
  - pattern <= pat_in; hist, fill cleared; state = IDLE; Dout = 0;
  - Din ignored that cycle; match_cnt unchanged.
- Priority: rst > pat_load > din_valid.
- No combinational path from any input to Dout.

Optional Feature:
- Macro: MOORE_SEQ_CNT_EN.
- Defined: match_cnt increments on every entry into MATCH and saturates at 2^CNT_W - 1. Cleared only by rst.
- Undefined: match_cnt port and counter logic are absent; no other behaviour changes.

Decomposition:
- Package moore_seq_pkg holds:
  - state enum typedef (IDLE = 2'd0, FILL = 2'd1, SCAN = 2'd2, MATCH = 2'd3);
  - localparam STATE_W = 2;
  - function fill_w(PAT_W) = $clog2(PAT_W + 1).
- One natural sub-module: seq_hist_reg, the history shift register plus saturating fill counter with clear/enable.
- The FSM and compare logic stay in the top.

Test Plan:
- Reset: after rst high for 2 cycles → Dout = 0, state_o = 0, match_cnt = 0; pattern = 1011 (PATTERN default).
- Overlap detect (OVERLAP = 1, PATTERN = 1011), din_valid = 1, bits 1,0,1,1,0,1,1 → Dout pulses one cycle after bit 4 and one cycle after bit 7; match_cnt = 2.
- Non-overlap (OVERLAP = 0), same stream → single pulse after bit 4; none after bit 7; state ends in FILL with fill = 3.
- Valid gaps: the stream 1,0,1,1 with din_valid = 0 for 3 cycles between each bit → exactly one Dout pulse, one cycle wide, after the 4th accepted bit; no pulse during the gaps.
- Runtime load: pat_load with pat_in = 0110 mid-stream → state IDLE, Dout = 0; then bits 0,1,1,0 → one pulse; stream 1,0,1,1 → no pulse.
- Reset/saturation:
  - rst asserted in the same cycle as the last pattern bit → no Dout pulse, state IDLE.
  - With CNT_W = 2 and 5 matches → match_cnt holds 3.
